// File: rtl/button_debouncer.sv
// Push-button conditioner between the board KEY pins and the button PIO.
// Each channel has three stages:
//   1. a 2-flop synchroniser,
//   2. a debounce/hold FSM,
//   3. registered outputs.
// Channels are fully independent of each other.
//
// Output semantics: press_pulse, release_pulse and long_press are
// single-cycle strobes. They are valid for exactly one clk_clk cycle and
// have no back-pressure, so a consumer must sample them every cycle.
// buttons_db and held_long are levels.
module button_debouncer #(
  parameter int N_BUTTONS     = 4,
  parameter int ACTIVE_LOW    = 1,
  parameter int STABLE_CYCLES = 1000000,
  parameter int LONG_CYCLES   = 50000000
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  input  logic [N_BUTTONS-1:0] buttons_raw,
  output logic [N_BUTTONS-1:0] buttons_db,
  output logic [N_BUTTONS-1:0] press_pulse,
  output logic [N_BUTTONS-1:0] release_pulse,
  output logic [N_BUTTONS-1:0] long_press,
  output logic [N_BUTTONS-1:0] held_long
);

  // Counter widths and terminal values.
  localparam int SW = $clog2(STABLE_CYCLES);
  localparam int HW = $clog2(LONG_CYCLES + 1);

  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_PRE  = HW'(LONG_CYCLES - 1);

  // Pin level that means "not pressed".
  localparam logic REL_LVL = (ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    RELEASED  = 2'd0,
    PRESS_CHK = 2'd1,
    PRESSED   = 2'd2,
    REL_CHK   = 2'd3
  } state_t;

  logic [N_BUTTONS-1:0] sync1;
  logic [N_BUTTONS-1:0] sync2;
  logic [N_BUTTONS-1:0] pressed_s;

  // Two-flop synchroniser.
  // It resets to the released level so that no false press is seen after reset.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      sync1 <= {N_BUTTONS{REL_LVL}};
      sync2 <= {N_BUTTONS{REL_LVL}};
    end else begin
      sync1 <= buttons_raw;
      sync2 <= sync1;
    end
  end

  // Normalise polarity: 1 always means pressed from here on.
  assign pressed_s = sync2 ^ {N_BUTTONS{REL_LVL}};

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
    // Per-channel state.
    // st is the visible FSM state for this channel.
    state_t          st;
    logic [SW-1:0]   stab_cnt;
    logic [HW-1:0]   hold_cnt;

    // Per-channel registered outputs.
    logic            db_r;
    logic            press_r;
    logic            release_r;
    logic            long_r;
    logic            held_r;

    // Debounce and hold FSM.
    // All outputs are registered here; strobes default low every cycle.
    always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
        st        <= RELEASED;
        stab_cnt  <= '0;
        hold_cnt  <= '0;
        db_r      <= REL_LVL;
        press_r   <= 1'b0;
        release_r <= 1'b0;
        long_r    <= 1'b0;
        held_r    <= 1'b0;
      end else begin
        press_r   <= 1'b0;
        release_r <= 1'b0;
        long_r    <= 1'b0;

        case (st)
          RELEASED: begin
            if (pressed_s[i]) begin
              st       <= PRESS_CHK;
              stab_cnt <= '0;
            end
          end

          PRESS_CHK: begin
            if (!pressed_s[i]) begin
              // Glitch: too short to be a press.
              st <= RELEASED;
            end else if (stab_cnt == STAB_LAST) begin
              st       <= PRESSED;
              db_r     <= ~REL_LVL;
              press_r  <= 1'b1;
              hold_cnt <= '0;
            end else begin
              stab_cnt <= stab_cnt + SW'(1);
            end
          end

          PRESSED: begin
            // Saturating hold counter.
            // long_press fires once, on the step that reaches the limit.
            if (hold_cnt != HOLD_MAX) begin
              hold_cnt <= hold_cnt + HW'(1);
              if (hold_cnt == HOLD_PRE) begin
                long_r <= 1'b1;
                held_r <= 1'b1;
              end
            end
            if (!pressed_s[i]) begin
              st       <= REL_CHK;
              stab_cnt <= '0;
            end
          end

          REL_CHK: begin
            // hold_cnt is frozen while a release is being qualified.
            if (pressed_s[i]) begin
              // Bounce: resume the press without any pulse.
              st <= PRESSED;
            end else if (stab_cnt == STAB_LAST) begin
              st        <= RELEASED;
              db_r      <= REL_LVL;
              release_r <= 1'b1;
              held_r    <= 1'b0;
              hold_cnt  <= '0;
            end else begin
              stab_cnt <= stab_cnt + SW'(1);
            end
          end

          default: begin
            st <= RELEASED;
          end
        endcase
      end
    end

    assign buttons_db[i]    = db_r;
    assign press_pulse[i]   = press_r;
    assign release_pulse[i] = release_r;
    assign long_press[i]    = long_r;
    assign held_long[i]     = held_r;
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer (STABLE_CYCLES=4, LONG_CYCLES=20).
// Stimulus pushes expected strobe events into exp_q. A negedge monitor pops
// and compares whenever any strobe is high. Level checks are made at quiet
// points in the sequence.
module tb_button_debouncer;

  localparam int N  = 4;
  localparam int W  = 52;
  localparam int SC = 4;
  localparam int LC = 20;

  // ---------------------------------------------------------------------
  // Clock and reset
  // ---------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] raw;
  logic [N-1:0] db;
  logic [N-1:0] pp;
  logic [N-1:0] rp;
  logic [N-1:0] lp;
  logic [N-1:0] hl;

  always #5 clk = ~clk;

  // Edge counter: after the k-th rising edge, cyc == k.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  button_debouncer #(
    .N_BUTTONS    (N),
    .ACTIVE_LOW   (1),
    .STABLE_CYCLES(SC),
    .LONG_CYCLES  (LC)
  ) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .buttons_raw  (raw),
    .buttons_db   (db),
    .press_pulse  (pp),
    .release_pulse(rp),
    .long_press   (lp),
    .held_long    (hl)
  );

  // ---------------------------------------------------------------------
  // Scoreboard
  // Each entry is {cycle, press, release, long, db, held}.
  // ---------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  function automatic logic [W-1:0] ev(
    input int       c,
    input logic [3:0] p,
    input logic [3:0] r,
    input logic [3:0] l,
    input logic [3:0] d,
    input logic [3:0] h
  );
    return {32'(c), p, r, l, d, h};
  endfunction

  // Monitor: any strobe on the DUT is an event that must match the queue head.
  always @(negedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] exp_v;
    if ((pp | rp | lp) != '0) begin
      got = {32'(cyc), pp, rp, lp, db, hl};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event cyc=%0d press=%b release=%b long=%b db=%b held=%b",
                 cyc, pp, rp, lp, db, hl);
      end else begin
        exp_v = exp_q.pop_front();
        if (got !== exp_v) begin
          failures++;
          $display("FAIL event got cyc=%0d p=%b r=%b l=%b db=%b h=%b exp cyc=%0d p=%b r=%b l=%b db=%b h=%b",
                   got[51:20], got[19:16], got[15:12], got[11:8], got[7:4], got[3:0],
                   exp_v[51:20], exp_v[19:16], exp_v[15:12], exp_v[11:8], exp_v[7:4], exp_v[3:0]);
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------

  // Advance n rising edges, then step 1 time unit off the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Level check at a quiet point: strobes must be low.
  task automatic check_lvl(
    input string    name,
    input logic [3:0] ed,
    input logic [3:0] eh
  );
    checks++;
    if (db !== ed || hl !== eh || pp !== 4'b0 || rp !== 4'b0 || lp !== 4'b0) begin
      failures++;
      $display("FAIL %s cyc=%0d db=%b held=%b p=%b r=%b l=%b exp db=%b held=%b strobes=0",
               name, cyc, db, hl, pp, rp, lp, ed, eh);
    end
  endtask

  // Watchdog: guarantees the run terminates even if the sequence stalls.
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog_timeout cyc=%0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin
    int t;

    // Reset held low with pins reading "all pressed".
    rst_n = 1'b0;
    raw   = 4'b0000;
    tick(3);
    check_lvl("reset_state", 4'b1111, 4'b0000);

    // Release reset with pins idle: no press may appear.
    rst_n = 1'b1;
    raw   = 4'b1111;
    tick(20);
    check_lvl("post_reset_idle", 4'b1111, 4'b0000);

    // Clean press on bit 0, held for 30 cycles.
    // The hold passes LONG_CYCLES, so a long press is expected too.
    t   = cyc;
    raw = 4'b1110;
    exp_q.push_back(ev(t + 7,  4'b0001, 4'b0000, 4'b0000, 4'b1110, 4'b0000));
    exp_q.push_back(ev(t + 27, 4'b0000, 4'b0000, 4'b0001, 4'b1110, 4'b0001));
    tick(6);
    check_lvl("press_not_early", 4'b1111, 4'b0000);
    tick(24);
    raw = 4'b1111;
    exp_q.push_back(ev(t + 37, 4'b0000, 4'b0001, 4'b0000, 4'b1111, 4'b0000));
    tick(20);
    check_lvl("clean_release_done", 4'b1111, 4'b0000);

    // Glitch on bit 1: low for only 3 cycles, so nothing may change.
    raw = 4'b1101;
    tick(3);
    raw = 4'b1111;
    tick(15);
    check_lvl("glitch_reject", 4'b1111, 4'b0000);

    // Bounce while pressed: bit 1 goes high for 2 cycles.
    // No release is expected for that bounce.
    t   = cyc;
    raw = 4'b1101;
    exp_q.push_back(ev(t + 7, 4'b0010, 4'b0000, 4'b0000, 4'b1101, 4'b0000));
    tick(10);
    raw = 4'b1111;
    tick(2);
    raw = 4'b1101;
    tick(4);
    check_lvl("bounce_hold", 4'b1101, 4'b0000);
    tick(2);
    raw = 4'b1111;
    exp_q.push_back(ev(t + 25, 4'b0000, 4'b0010, 4'b0000, 4'b1111, 4'b0000));
    tick(15);
    check_lvl("bounce_release_done", 4'b1111, 4'b0000);

    // Long press on bit 2, held for 40 cycles.
    t   = cyc;
    raw = 4'b1011;
    exp_q.push_back(ev(t + 7,  4'b0100, 4'b0000, 4'b0000, 4'b1011, 4'b0000));
    exp_q.push_back(ev(t + 27, 4'b0000, 4'b0000, 4'b0100, 4'b1011, 4'b0100));
    tick(30);
    check_lvl("held_long_set", 4'b1011, 4'b0100);
    tick(10);
    raw = 4'b1111;
    exp_q.push_back(ev(t + 47, 4'b0000, 4'b0100, 4'b0000, 4'b1111, 4'b0000));
    tick(6);
    check_lvl("held_until_release", 4'b1011, 4'b0100);
    tick(2);
    check_lvl("held_cleared", 4'b1111, 4'b0000);
    tick(10);

    // Simultaneous press on all bits, then staggered releases.
    // Bit 3 stays held long enough to reach a long press.
    t   = cyc;
    raw = 4'b0000;
    exp_q.push_back(ev(t + 7, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    tick(10);
    raw = 4'b0001;
    exp_q.push_back(ev(t + 17, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0000));
    tick(2);
    raw = 4'b0011;
    exp_q.push_back(ev(t + 19, 4'b0000, 4'b0010, 4'b0000, 4'b0011, 4'b0000));
    tick(2);
    raw = 4'b0111;
    exp_q.push_back(ev(t + 21, 4'b0000, 4'b0100, 4'b0000, 4'b0111, 4'b0000));
    exp_q.push_back(ev(t + 27, 4'b0000, 4'b0000, 4'b1000, 4'b0111, 4'b1000));
    tick(16);
    check_lvl("held_before_reset", 4'b0111, 4'b1000);

    // Reset while bit 3 is in PRESSED with held_long set.
    // The reset itself must not produce a release pulse.
    rst_n = 1'b0;
    raw   = 4'b1111;
    tick(1);
    check_lvl("reset_mid_press", 4'b1111, 4'b0000);
    tick(1);
    rst_n = 1'b1;
    tick(20);
    check_lvl("final_idle", 4'b1111, 4'b0000);

    // Every expected event must have been consumed by the monitor.
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_events left=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
